// File: rtl/arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding and the
// default word width / depth that DataMemory is also built with.
package arb_pkg;

    localparam int ARB_WIDTH = 36;
    localparam int ARB_DEPTH = 2048;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arbState_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Core-side request bus plus DataMemory port as seen by the arbiter.
// master = arbiter side, slave = cores and memory side.
interface data_memory_arbiter_if #(
    parameter int NUM_CORES  = 4,
    parameter int WIDTH      = 36,
    parameter int ADDR_WIDTH = 11
);
    logic [NUM_CORES-1:0]            coreReq;
    logic [NUM_CORES-1:0]            coreWriteEn;
    logic [NUM_CORES*ADDR_WIDTH-1:0] coreAddress;
    logic [NUM_CORES*WIDTH-1:0]      coreDataIn;
    logic [NUM_CORES-1:0]            coreDone;
    logic [NUM_CORES-1:0]            coreAck;
    logic [WIDTH-1:0]                coreDataOut;
    logic                            memWriteEn;
    logic [ADDR_WIDTH-1:0]           memAddress;
    logic [WIDTH-1:0]                memDataIn;
    logic [WIDTH-1:0]                memDataOut;
    logic                            memProcessDone;

    modport master (
        input  coreReq, coreWriteEn, coreAddress, coreDataIn, coreDone, memDataOut,
        output coreAck, coreDataOut, memWriteEn, memAddress, memDataIn, memProcessDone
    );

    modport slave (
        output coreReq, coreWriteEn, coreAddress, coreDataIn, coreDone, memDataOut,
        input  coreAck, coreDataOut, memWriteEn, memAddress, memDataIn, memProcessDone
    );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// Combinational winner select, one-hot grant out.
// ARB_FIXED_PRIORITY_EN: lowest requesting index always wins, no lastGrant input.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_WIDTH = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    output logic [NUM_CORES-1:0] grant
`ifndef ARB_FIXED_PRIORITY_EN
    ,
    input  logic [IDX_WIDTH-1:0] lastGrant
`endif
);

    logic found;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    // Scan offsets 1..NUM_CORES past the last winner; compare against each
    // constant index so no variable bit-select is needed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!found && req[i] && (i == ((int'(lastGrant) + off) % NUM_CORES))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises NUM_CORES load/store requests onto the single DataMemory port.
// ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
//
// state   | meaning
// IDLE    | waiting for a request; winner fields latched on leaving
// ACCESS  | memory access in progress, READ_LATENCY cycles
// RESPOND | one-cycle coreAck to the winner
module data_memory_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int WIDTH        = ARB_WIDTH,
    parameter int DEPTH        = ARB_DEPTH,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 resetN,
    data_memory_arbiter_if.master bus
);

    localparam int IDX_WIDTH = $clog2(NUM_CORES);
    localparam int CNT_WIDTH = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(READ_LATENCY - 1);

    arbState_t             state, stateNext;
    logic [CNT_WIDTH-1:0]  cnt, cntNext;
    logic [NUM_CORES-1:0]  grant;
    logic [NUM_CORES-1:0]  ackVec;
    logic [IDX_WIDTH-1:0]  winner, winnerSel;
    logic                  writeReg, selWrite;
    logic [ADDR_WIDTH-1:0] addrReg, selAddr;
    logic [WIDTH-1:0]      dataReg, selData;
    logic [WIDTH-1:0]      readReg;
    logic                  loadFields, captureRead;
    logic                  doneReg;

`ifdef ARB_FIXED_PRIORITY_EN
    rr_arbiter #(.NUM_CORES(NUM_CORES)) uArb (
        .req   (bus.coreReq),
        .grant (grant)
    );
`else
    logic [IDX_WIDTH-1:0] lastGrant;

    rr_arbiter #(.NUM_CORES(NUM_CORES)) uArb (
        .req       (bus.coreReq),
        .grant     (grant),
        .lastGrant (lastGrant)
    );

    // Reset value makes core 0 the first winner.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lastGrant <= IDX_WIDTH'(NUM_CORES - 1);
        end else if (state == RESPOND) begin
            lastGrant <= winner;
        end
    end
`endif

    always_comb begin
        winnerSel = '0;
        selWrite  = 1'b0;
        selAddr   = '0;
        selData   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                winnerSel = IDX_WIDTH'(i);
                selWrite  = bus.coreWriteEn[i];
                selAddr   = bus.coreAddress[i*ADDR_WIDTH +: ADDR_WIDTH];
                selData   = bus.coreDataIn[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        loadFields  = 1'b0;
        captureRead = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.coreReq) begin
                    stateNext  = ACCESS;
                    cntNext    = CNT_INIT;
                    loadFields = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    stateNext   = RESPOND;
                    captureRead = !writeReg;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            RESPOND: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        ackVec = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            ackVec[i] = (state == RESPOND) && (winner == IDX_WIDTH'(i));
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            winner   <= '0;
            writeReg <= 1'b0;
            addrReg  <= '0;
            dataReg  <= '0;
            readReg  <= '0;
            doneReg  <= 1'b0;
        end else begin
            if (loadFields) begin
                winner   <= winnerSel;
                writeReg <= selWrite;
                addrReg  <= selAddr;
                dataReg  <= selData;
            end
            if (captureRead) begin
                readReg <= bus.memDataOut;
            end
            // Sticky: only reset clears it.
            if ((&bus.coreDone) && (state == IDLE) && (bus.coreReq == '0)) begin
                doneReg <= 1'b1;
            end
        end
    end

    // Counter sits at CNT_INIT only in the first ACCESS cycle: one write pulse per store.
    assign bus.memWriteEn     = (state == ACCESS) && (cnt == CNT_INIT) && writeReg;
    assign bus.memAddress     = addrReg;
    assign bus.memDataIn      = dataReg;
    assign bus.coreDataOut    = readReg;
    assign bus.coreAck        = ackVec;
    assign bus.memProcessDone = doneReg;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: one DUT with READ_LATENCY=1, one with 3,
// each backed by a small behavioural DataMemory.
module tb_data_memory_arbiter;

    logic clock;
    logic resetN;
    int   tests  = 0;
    int   failed = 0;

    data_memory_arbiter_if #(.NUM_CORES(4), .WIDTH(36), .ADDR_WIDTH(11)) bus1 ();
    data_memory_arbiter_if #(.NUM_CORES(4), .WIDTH(36), .ADDR_WIDTH(11)) bus3 ();

    data_memory_arbiter #(.NUM_CORES(4), .WIDTH(36), .DEPTH(2048), .ADDR_WIDTH(11),
                          .READ_LATENCY(1)) dut1 (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus1.master)
    );

    data_memory_arbiter #(.NUM_CORES(4), .WIDTH(36), .DEPTH(2048), .ADDR_WIDTH(11),
                          .READ_LATENCY(3)) dut3 (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus3.master)
    );

    // Latency-1 memory: data for the presented address is valid in the same cycle.
    logic [35:0] mem1 [0:2047];
    assign bus1.memDataOut = mem1[bus1.memAddress];
    always @(posedge clock) if (bus1.memWriteEn) mem1[bus1.memAddress] <= bus1.memDataIn;

    // Latency-3 memory: two extra register stages behind the array read.
    logic [35:0] mem3 [0:2047];
    logic [35:0] rd3a, rd3b;
    assign bus3.memDataOut = rd3b;
    always @(posedge clock) begin
        if (bus3.memWriteEn) mem3[bus3.memAddress] <= bus3.memDataIn;
        rd3a <= mem3[bus3.memAddress];
        rd3b <= rd3a;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] ackOrder [0:3];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i] <= 36'h0;
            mem3[i] <= 36'h0;
        end
        mem3[11'h123] <= 36'hFEDCBA987;
        rd3a <= 36'h0;
        rd3b <= 36'h0;

        resetN           = 1'b0;
        bus1.coreReq     = 4'b1111;
        bus1.coreWriteEn = 4'b0000;
        bus1.coreAddress = '0;
        bus1.coreDataIn  = '0;
        bus1.coreDone    = 4'b0000;
        bus3.coreReq     = 4'b0000;
        bus3.coreWriteEn = 4'b0000;
        bus3.coreAddress = '0;
        bus3.coreDataIn  = '0;
        bus3.coreDone    = 4'b0000;

        // Reset held with all cores requesting
        tick();
        tick();
        chk("rst_ack",      64'(bus1.coreAck), 64'h0);
        chk("rst_wen",      64'(bus1.memWriteEn), 64'h0);
        chk("rst_addr",     64'(bus1.memAddress), 64'h0);
        chk("rst_din",      64'(bus1.memDataIn), 64'h0);
        chk("rst_dout",     64'(bus1.coreDataOut), 64'h0);
        chk("rst_pdone",    64'(bus1.memProcessDone), 64'h0);
        chk("rst_ack_l3",   64'(bus3.coreAck), 64'h0);

        resetN = 1'b1;
        tick();
        chk("first_access_ack", 64'(bus1.coreAck), 64'h0);
        tick();
        chk("first_ack_core0", 64'(bus1.coreAck), 64'h1);
        bus1.coreReq = 4'b0000;
        tick();
        chk("first_ack_gone", 64'(bus1.coreAck), 64'h0);

        // Core 2 store 36'hABC @ 11'h005
        bus1.coreReq               = 4'b0100;
        bus1.coreWriteEn           = 4'b0100;
        bus1.coreAddress[22 +: 11] = 11'h005;
        bus1.coreDataIn[72 +: 36]  = 36'h000000ABC;
        tick();
        chk("st_wen_c1",  64'(bus1.memWriteEn), 64'h1);
        chk("st_addr_c1", 64'(bus1.memAddress), 64'h005);
        chk("st_din_c1",  64'(bus1.memDataIn), 64'hABC);
        chk("st_ack_c1",  64'(bus1.coreAck), 64'h0);
        tick();
        chk("st_wen_c2",  64'(bus1.memWriteEn), 64'h0);
        chk("st_ack_c2",  64'(bus1.coreAck), 64'h4);
        chk("st_dout_unchanged", 64'(bus1.coreDataOut), 64'h0);
        // Same core presents a load the cycle after its ack
        bus1.coreWriteEn = 4'b0000;
        tick();
        chk("ld_idle_wen",  64'(bus1.memWriteEn), 64'h0);
        chk("ld_idle_addr", 64'(bus1.memAddress), 64'h005);
        chk("ld_idle_ack",  64'(bus1.coreAck), 64'h0);
        tick();
        chk("ld_access_wen", 64'(bus1.memWriteEn), 64'h0);
        tick();
        chk("ld_ack",  64'(bus1.coreAck), 64'h4);
        chk("ld_dout", 64'(bus1.coreDataOut), 64'hABC);
        bus1.coreReq = 4'b0000;
        tick();

        // Core 3 load of the same word; lastGrant ends at 3
        bus1.coreReq               = 4'b1000;
        bus1.coreAddress[33 +: 11] = 11'h005;
        tick();
        tick();
        chk("c3_ack",  64'(bus1.coreAck), 64'h8);
        chk("c3_dout", 64'(bus1.coreDataOut), 64'hABC);
        bus1.coreReq = 4'b0000;
        tick();

        // Contention 4'b1011 held: order 0,1,3,0 at 3-cycle spacing
        ackOrder[0] = 4'b0001;
        ackOrder[1] = 4'b0010;
        ackOrder[2] = 4'b1000;
        ackOrder[3] = 4'b0001;
        bus1.coreReq = 4'b1011;
        tick();
        tick();
        chk("rr_ack0", 64'(bus1.coreAck), 64'(ackOrder[0]));
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("rr_gap_a", 64'(bus1.coreAck), 64'h0);
            tick();
            chk("rr_gap_b", 64'(bus1.coreAck), 64'h0);
            tick();
            chk("rr_ack", 64'(bus1.coreAck), 64'(ackOrder[k]));
        end
        bus1.coreReq = 4'b0000;
        tick();

        // READ_LATENCY=3: core 1 load @ 11'h123
        bus3.coreReq               = 4'b0010;
        bus3.coreAddress[11 +: 11] = 11'h123;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("l3_addr", 64'(bus3.memAddress), 64'h123);
            chk("l3_wen",  64'(bus3.memWriteEn), 64'h0);
            chk("l3_ack",  64'(bus3.coreAck), 64'h0);
            bus3.coreAddress[11 +: 11] = 11'h7FF;
        end
        tick();
        chk("l3_ack_c4",  64'(bus3.coreAck), 64'h2);
        chk("l3_dout",    64'(bus3.coreDataOut), 64'hFEDCBA987);
        chk("l3_wen_c4",  64'(bus3.memWriteEn), 64'h0);
        bus3.coreReq = 4'b0000;
        tick();

        // Reset during an ACCESS cycle of a core 1 store
        bus1.coreReq               = 4'b0010;
        bus1.coreWriteEn           = 4'b0010;
        bus1.coreAddress[11 +: 11] = 11'h007;
        bus1.coreDataIn[36 +: 36]  = 36'h000000111;
        tick();
        chk("mid_pre_wen", 64'(bus1.memWriteEn), 64'h1);
        resetN = 1'b0;
        #1;
        chk("mid_rst_wen",  64'(bus1.memWriteEn), 64'h0);
        chk("mid_rst_ack",  64'(bus1.coreAck), 64'h0);
        chk("mid_rst_addr", 64'(bus1.memAddress), 64'h0);
        bus1.coreReq     = 4'b0000;
        bus1.coreWriteEn = 4'b0000;
        tick();
        chk("mid_hold_ack", 64'(bus1.coreAck), 64'h0);
        resetN = 1'b1;
        tick();
        chk("mid_idle_ack", 64'(bus1.coreAck), 64'h0);
        chk("mid_idle_wen", 64'(bus1.memWriteEn), 64'h0);
        tick();
        chk("mid_idle_ack2", 64'(bus1.coreAck), 64'h0);
        bus1.coreReq               = 4'b0010;
        bus1.coreAddress[11 +: 11] = 11'h005;
        tick();
        chk("mid_reissue_ack_c1", 64'(bus1.coreAck), 64'h0);
        tick();
        chk("mid_reissue_ack", 64'(bus1.coreAck), 64'h2);
        chk("mid_reissue_dout", 64'(bus1.coreDataOut), 64'hABC);
        bus1.coreReq = 4'b0000;
        tick();

        // processDone with core 3 still requesting
        chk("pd_before", 64'(bus1.memProcessDone), 64'h0);
        bus1.coreDone = 4'b1111;
        bus1.coreReq  = 4'b1000;
        tick();
        chk("pd_access", 64'(bus1.memProcessDone), 64'h0);
        tick();
        chk("pd_respond", 64'(bus1.memProcessDone), 64'h0);
        chk("pd_c3_ack",  64'(bus1.coreAck), 64'h8);
        bus1.coreReq = 4'b0000;
        tick();
        chk("pd_idle_first", 64'(bus1.memProcessDone), 64'h0);
        tick();
        chk("pd_set", 64'(bus1.memProcessDone), 64'h1);
        bus1.coreDone = 4'b0000;
        tick();
        tick();
        chk("pd_sticky", 64'(bus1.memProcessDone), 64'h1);
        chk("pd_l3_never", 64'(bus3.memProcessDone), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
